// File: rtl/std_stream_demux.sv
// Registered 1:N valid/ready stream demux; each beat is steered to one output by its own select.
// Latency: one cycle from acceptance to o_valid; one beat per cycle while the target output is ready.
// Backpressure: o_ready falls only while a held beat's target is not ready; other outputs' ready is ignored.

package std_selector_pkg;

  typedef enum logic [1:0] {
    selector_kind_BINARY,
    selector_kind_VECTOR,
    selector_kind_ONEHOT
  } selector_kind_e;

  function automatic int calc_select_width(input int entries, input selector_kind_e kind);
    if (kind == selector_kind_BINARY) return (entries > 1) ? $clog2(entries) : 1;
    return entries;
  endfunction

endpackage

module std_stream_demux #(
  parameter int WIDTH = 1,
  parameter type DATA_TYPE = logic [WIDTH-1:0],
  parameter int ENTRIES = 2,
  parameter std_selector_pkg::selector_kind_e KIND = std_selector_pkg::selector_kind_BINARY,
  localparam int SELECT_WIDTH = std_selector_pkg::calc_select_width(ENTRIES, KIND)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [SELECT_WIDTH-1:0] i_select,
  input  DATA_TYPE                i_data,
  output logic [ENTRIES-1:0]      o_valid,
  input  logic [ENTRIES-1:0]      i_ready,
  output DATA_TYPE                o_data [ENTRIES],
  output logic                    o_drop
);

  localparam int DST_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_e;

  state_e           state;
  DATA_TYPE         data_q;
  logic [DST_W-1:0] dst_q;
  logic [DST_W-1:0] sel_dst;
  logic             sel_ok;
  logic             full;
  logic             pop;
  logic             accept;
  logic             push;

  // Select decode; every beat either lands on one output or is reported as dropped.
  if (ENTRIES == 1) begin : g_single
    logic unused_select;
    assign unused_select = ^i_select;
    assign sel_dst       = '0;
    assign sel_ok        = 1'b1;
  end else if (KIND == std_selector_pkg::selector_kind_BINARY) begin : g_binary
    assign sel_dst = i_select;
    assign sel_ok  = (i_select <= SELECT_WIDTH'(ENTRIES - 1));
  end else begin : g_vector
    // Multi-hot selects resolve to the lowest set bit so routing stays deterministic.
    always_comb begin
      sel_dst = '0;
      for (int k = ENTRIES - 1; k >= 0; k--) begin
        if (i_select[k]) sel_dst = DST_W'(k);
      end
    end
    assign sel_ok = |i_select;
  end

  assign full    = (state == S_FULL);
  assign pop     = |(o_valid & i_ready);
  assign o_ready = !full || pop;
  assign accept  = i_valid && o_ready;
  assign push    = accept && sel_ok;

  always_comb begin
    o_valid = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      o_valid[k] = full && (dst_q == DST_W'(k));
      o_data[k]  = data_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_EMPTY;
      o_drop <= 1'b0;
    end else begin
      o_drop <= accept && !sel_ok;
      case (state)
        S_EMPTY: if (push) state <= S_FULL;
        S_FULL:  if (pop && !push) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Payload is only observed behind o_valid, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      data_q <= i_data;
      dst_q  <= sel_dst;
    end
  end

endmodule

// File: tb/tb_std_stream_demux.sv
// Bench for std_stream_demux: directed routing/backpressure/drop/reset steps plus a random run
// against per-output expected-beat queues.
module tb_std_stream_demux;
  import std_selector_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // BINARY, 4 outputs
  logic       a_valid, a_oready, a_drop;
  logic [1:0] a_sel;
  logic [7:0] a_data;
  logic [3:0] a_ovalid, a_irdy;
  logic [7:0] a_odata [4];

  // VECTOR, 4 outputs
  logic       b_valid, b_oready, b_drop;
  logic [3:0] b_sel;
  logic [7:0] b_data;
  logic [3:0] b_ovalid, b_irdy;
  logic [7:0] b_odata [4];

  // BINARY, 3 outputs
  logic       c_valid, c_oready, c_drop;
  logic [1:0] c_sel;
  logic [7:0] c_data;
  logic [2:0] c_ovalid, c_irdy;
  logic [7:0] c_odata [3];

  std_stream_demux #(.WIDTH(8), .ENTRIES(4), .KIND(selector_kind_BINARY)) u_bin4 (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_oready), .i_select(a_sel),
    .i_data(a_data), .o_valid(a_ovalid), .i_ready(a_irdy), .o_data(a_odata), .o_drop(a_drop));

  std_stream_demux #(.WIDTH(8), .ENTRIES(4), .KIND(selector_kind_VECTOR)) u_vec4 (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_oready), .i_select(b_sel),
    .i_data(b_data), .o_valid(b_ovalid), .i_ready(b_irdy), .o_data(b_odata), .o_drop(b_drop));

  std_stream_demux #(.WIDTH(8), .ENTRIES(3), .KIND(selector_kind_BINARY)) u_bin3 (
    .i_clk(clk), .i_rst(rst), .i_valid(c_valid), .o_ready(c_oready), .i_select(c_sel),
    .i_data(c_data), .o_valid(c_ovalid), .i_ready(c_irdy), .o_data(c_odata), .o_drop(c_drop));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int low_bit(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return -1;
  endfunction

  // Random-run model: beats still owed on each output, in order.
  logic [7:0] q [4][$];
  int         pending;
  int         dst;
  int         exp_drops, obs_drops, pushed, delivered;
  logic       exp_drop;
  logic       exp_rdy;
  logic [3:0] one_hot;

  initial begin
    rst = 1'b1;
    a_valid = 0; a_sel = 0; a_data = 0; a_irdy = 0;
    b_valid = 0; b_sel = 0; b_data = 0; b_irdy = 0;
    c_valid = 0; c_sel = 0; c_data = 0; c_irdy = 0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_ovalid", a_ovalid, 4'b0000);
    check("reset_drop", a_drop, 1'b0);
    check("reset_oready", a_oready, 1'b1);

    // Two beats to different outputs, back to back.
    tick();
    a_valid = 1; a_sel = 2; a_data = 8'hA1; a_irdy = 4'hF;
    @(negedge clk);
    check("t1_empty_ovalid", a_ovalid, 4'b0000);
    check("t1_oready0", a_oready, 1'b1);
    tick();
    a_sel = 0; a_data = 8'hB2;
    @(negedge clk);
    check("t1_ovalid_a", a_ovalid, 4'b0100);
    check("t1_data_a", a_odata[2], 8'hA1);
    check("t1_oready1", a_oready, 1'b1);
    tick();
    a_valid = 0;
    @(negedge clk);
    check("t1_ovalid_b", a_ovalid, 4'b0001);
    check("t1_data_b", a_odata[0], 8'hB2);
    tick();
    @(negedge clk);
    check("t1_drained", a_ovalid, 4'b0000);

    // Target not ready for five cycles while a non-target output is ready.
    tick();
    a_valid = 1; a_sel = 1; a_data = 8'hA1; a_irdy = 4'b0001;
    tick();
    a_data = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_ovalid", a_ovalid, 4'b0010);
      check("t2_hold_data", a_odata[1], 8'hA1);
      check("t2_hold_oready", a_oready, 1'b0);
      tick();
    end
    a_irdy = 4'b0011;
    @(negedge clk);
    check("t2_release_oready", a_oready, 1'b1);
    check("t2_release_data", a_odata[1], 8'hA1);
    tick();
    a_valid = 0;
    @(negedge clk);
    check("t2_second_ovalid", a_ovalid, 4'b0010);
    check("t2_second_data", a_odata[1], 8'hC3);
    tick();
    @(negedge clk);
    check("t2_drained", a_ovalid, 4'b0000);

    // Invalid selects are consumed and flagged one cycle later.
    c_irdy = 3'b111;
    tick();
    c_valid = 1; c_sel = 3; c_data = 8'h11;
    @(negedge clk);
    check("t3_bin3_oready", c_oready, 1'b1);
    check("t3_bin3_drop_early", c_drop, 1'b0);
    tick();
    c_valid = 0;
    @(negedge clk);
    check("t3_bin3_drop", c_drop, 1'b1);
    check("t3_bin3_ovalid", c_ovalid, 3'b000);
    tick();
    @(negedge clk);
    check("t3_bin3_drop_pulse", c_drop, 1'b0);
    c_valid = 1; c_sel = 2; c_data = 8'h22;
    tick();
    c_valid = 0;
    @(negedge clk);
    check("t3_bin3_top_ovalid", c_ovalid, 3'b100);
    check("t3_bin3_top_data", c_odata[2], 8'h22);
    check("t3_bin3_top_drop", c_drop, 1'b0);

    b_irdy = 4'hF;
    tick();
    b_valid = 1; b_sel = 4'b0000; b_data = 8'h33;
    tick();
    b_valid = 0;
    @(negedge clk);
    check("t3_vec_drop", b_drop, 1'b1);
    check("t3_vec_ovalid", b_ovalid, 4'b0000);

    // Multi-hot select goes to the lowest set bit.
    tick();
    b_valid = 1; b_sel = 4'b1010; b_data = 8'h5C;
    tick();
    b_valid = 0;
    @(negedge clk);
    check("t4_ovalid", b_ovalid, 4'b0010);
    check("t4_data", b_odata[1], 8'h5C);
    check("t4_drop", b_drop, 1'b0);

    // Reset while a beat is held: it must never come out.
    tick();
    a_valid = 1; a_sel = 3; a_data = 8'h77; a_irdy = 4'h0;
    tick();
    a_valid = 0;
    @(negedge clk);
    check("t5_held", a_ovalid, 4'b1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_irdy = 4'hF;
    @(negedge clk);
    check("t5_ovalid", a_ovalid, 4'b0000);
    check("t5_drop", a_drop, 1'b0);
    check("t5_oready", a_oready, 1'b1);
    tick();
    @(negedge clk);
    check("t5_never_delivered", a_ovalid, 4'b0000);

    // Random run on the VECTOR instance.
    exp_drop = 0; exp_drops = 0; obs_drops = 0; pushed = 0; delivered = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      b_valid = ($urandom_range(0, 3) != 0);
      b_sel   = 4'($urandom_range(0, 15));
      b_data  = 8'($urandom);
      b_irdy  = 4'($urandom);
      @(negedge clk);
      pending = -1;
      for (int k = 0; k < 4; k++) if (q[k].size() > 0) pending = k;
      one_hot = (pending >= 0) ? (4'b0001 << pending) : 4'b0000;
      exp_rdy = (pending < 0) || b_irdy[pending];
      check("fz_ovalid", b_ovalid, one_hot);
      check("fz_oready", b_oready, exp_rdy);
      check("fz_drop", b_drop, exp_drop);
      if (b_drop) obs_drops++;
      if (pending >= 0) begin
        check("fz_data", b_odata[pending], q[pending][0]);
        if (b_irdy[pending]) begin
          void'(q[pending].pop_front());
          delivered++;
        end
      end
      exp_drop = 0;
      if (b_valid && exp_rdy) begin
        dst = low_bit(b_sel);
        if (dst < 0) begin
          exp_drop = 1;
          exp_drops++;
        end else begin
          q[dst].push_back(b_data);
          pushed++;
        end
      end
    end
    tick();
    b_valid = 0; b_irdy = 4'hF;
    @(negedge clk);
    if (b_drop) obs_drops++;
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() > 0) begin
        check("fz_tail_ovalid", b_ovalid[k], 1'b1);
        check("fz_tail_data", b_odata[k], q[k][0]);
        void'(q[k].pop_front());
        delivered++;
      end
    end
    tick();
    @(negedge clk);
    check("fz_final_empty", b_ovalid, 4'b0000);
    check("fz_drop_count", obs_drops, exp_drops);
    check("fz_delivered", delivered, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
